iic_drive: RTL and testbench
============================

IIC_DRIVE -- requirements
Module: iic_drive

Interface
REQ-001 SHALL have parameter QTR_CYCLES, default 1, meaning clk_i cycles per SCL quarter-period (SCL = clk_i/(4*QTR_CYCLES); 400 kHz clk_i gives 100 kHz SCL).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-high reset (1 = reset).
REQ-005 SHALL have port wr_rd_flag, input, 1, transaction type (0 = write, 1 = read).
REQ-006 SHALL have port start_en, input, 1, single-cycle transaction request.
REQ-007 SHALL have port i2c_device_addr, input, 8, 7-bit address in [7:1]; bit 0 is ignored.
REQ-008 SHALL have port register, input, 16, target register address, sent MSB byte first.
REQ-009 SHALL have port data_byte, input, 8, write payload.
REQ-010 SHALL have port scl, output, 1, I2C clock, push-pull.
REQ-011 SHALL have port sda, inout, 1, I2C data, open-drain: drives 0 or Z, never 1.
REQ-012 SHALL have port busy, output, 1, transaction in progress.
REQ-013 SHALL have port err, output, 1, slave NACK seen in last transaction.
REQ-014 SHALL have port rd_data, output, 8, byte returned by last successful read.

Function
REQ-015 SHALL accept start_en only while busy=0; when accepted, it latches all inputs and sets busy=1 on the next clk_i edge; start_en while busy SHALL be ignored.
REQ-016 SHALL use FSM states IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, DONE.
REQ-017 SHALL divide each bit into 4 quarters: q0 scl=0 with sda updated; q1/q2 scl=1 with sda sampled at end of q1; q3 scl=0.
REQ-018 SHALL generate START as sda falling while scl=1, and STOP as sda rising while scl=1.
REQ-019 SHALL run write as: START, {addr[7:1],0}, ACK, reg[15:8], ACK, reg[7:0], ACK, data_byte, ACK, STOP.
REQ-020 SHALL run read as: START, {addr[7:1],0}, ACK, reg[15:8], ACK, reg[7:0], ACK, RESTART, {addr[7:1],1}, ACK, 8 bits read MSB first, master NACK (sda released), STOP.
REQ-021 SHALL shift bytes MSB first and release sda during every ACK slot.
REQ-022 SHALL treat sda=1 in an ACK slot as NACK: set err=1, skip to STOP, and leave rd_data unchanged.
REQ-023 SHALL clear err when a new request is accepted; otherwise err holds until then.
REQ-024 SHALL update rd_data only in DONE of a read with no NACK.
REQ-025 SHALL deassert busy in the cycle after STOP completes (DONE → IDLE), then leave scl=1 and sda released.

Reset
REQ-026 SHALL on rst_n=1 set scl=1, release sda, busy=0, err=0, rd_data=0x00, FSM to IDLE, and clear counters.
REQ-027 SHALL, on reset during a transaction, abort immediately with no STOP generated.

Configuration
REQ-028 SHALL provide macro IIC_READ_EN.
REQ-029 SHALL, with IIC_READ_EN defined, support the read flow of REQ-020.
REQ-030 SHALL, without IIC_READ_EN, ignore wr_rd_flag (every transaction is a write), exclude RESTART/RX_BYTE/TX_NACK logic, and tie rd_data to 0x00.

Structure
REQ-031 SHALL place the FSM state enum, the R/W bit constants (WR=0, RD=1) and the bit/quarter count widths in shared package iic_pkg.
REQ-032 SHALL implement quarter-tick generation (QTR_CYCLES counter, 2-bit quarter index) in a single sub-module named iic_phase_gen; the byte/bit FSM remains in iic_drive.

Verification
REQ-033 Write, ACKing slave model: addr 0x78, reg 0x3008, data 0x82 → bus bytes 0x78,0x30,0x08,0x82, each ACKed, then STOP; busy high 1 cycle after start_en, low after STOP; err=0.
REQ-034 Read, slave returns 0x56: addr 0x78, reg 0x300A → 0x78,0x30,0x0A, repeated START, 0x79, master samples 0x56 then NACK, STOP; rd_data=0x56; err=0.
REQ-035 Address NACK (no slave): write to addr 0x42 → err=1 after first ACK slot, STOP immediately, no further bytes, busy=0; next accepted start_en clears err.
REQ-036 start_en pulsed mid-write → ignored; the in-flight transaction completes unchanged, and no second transaction follows.
REQ-037 rst_n=1 asserted during the register-high byte → next cycle scl=1, sda=Z, busy=0, err=0.
REQ-038 Build without IIC_READ_EN, wr_rd_flag=1 → write sequence of REQ-033 on the bus; rd_data stays 0x00.

Source files
------------

// File: rtl/iic_pkg.sv
// iic_pkg: shared FSM states, R/W bit values and counter widths for the I2C master
package iic_pkg;
  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, DONE
  } state_t;
  localparam logic WR = 1'b0;
  localparam logic RD = 1'b1;
  localparam int BIT_W = 3;
  localparam int QTR_W = 2;
endpackage

// File: rtl/iic_phase_gen.sv
// iic_phase_gen: splits each I2C bit into four quarters of QTR_CYCLES clk_i cycles
//   clk_i, rst_n (sync, active-high) ; run holds the generator at quarter 0 while low
//   q: current quarter ; mid: first cycle of q2 (bus-visible end of q1, since bus pins lag one cycle)
//   bit_end: last cycle of q3
module iic_phase_gen
  import iic_pkg::*;
#(
  parameter int QTR_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             run,
  output logic [QTR_W-1:0] q,
  output logic             mid,
  output logic             bit_end
);
  localparam int CW = QTR_CYCLES > 1 ? $clog2(QTR_CYCLES) : 1;
  logic [CW-1:0] cnt;
  logic tick;
  assign tick = cnt == CW'(QTR_CYCLES - 1);
  assign mid = run && q == 2'd2 && cnt == '0;
  assign bit_end = run && q == 2'd3 && tick;
  always_ff @(posedge clk_i)
    if (rst_n || !run) begin
      cnt <= '0;
      q <= '0;
    end else if (tick) begin
      cnt <= '0;
      q <= q + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/iic_drive.sv
// iic_drive: I2C master issuing 16-bit-register writes and (with IIC_READ_EN) single-byte reads
//   clk_i, rst_n (sync, active-high) ; start_en accepted only while busy=0
//   wr_rd_flag 0=write 1=read ; i2c_device_addr[7:1] slave address ; register sent MSB byte first
//   data_byte write payload ; scl push-pull ; sda open-drain (0 or Z)
//   busy in-flight ; err last transaction NACKed ; rd_data last good read byte
//   Macro IIC_READ_EN enables the read flow; without it every transaction is a write and rd_data=0
module iic_drive
  import iic_pkg::*;
#(
  parameter int QTR_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        wr_rd_flag,
  input  logic        start_en,
  input  logic [7:0]  i2c_device_addr,
  input  logic [15:0] register,
  input  logic [7:0]  data_byte,
  output logic        scl,
  inout  wire         sda,
  output logic        busy,
  output logic        err,
  output logic [7:0]  rd_data
);
  state_t state;
  logic [QTR_W-1:0] q;
  logic [BIT_W-1:0] bit_cnt;
  logic [1:0] ph;
  logic [6:0] addr;
  logic [15:0] regs;
  logic [7:0] data, sh;
  logic run, mid, bit_end, hi, rd, ack_n, sda_low, scl_nx, low_nx, unused_in;
  assign unused_in = ^{i2c_device_addr[0], wr_rd_flag};
  assign run = state != IDLE && state != DONE;
  assign sda = sda_low ? 1'b0 : 1'bz;
  iic_phase_gen #(.QTR_CYCLES(QTR_CYCLES)) u_phase (
    .clk_i(clk_i), .rst_n(rst_n), .run(run), .q(q), .mid(mid), .bit_end(bit_end)
  );
  assign hi = q == 2'd1 || q == 2'd2;
  // START/RESTART pull sda low in q2 with scl high; STOP releases it in q2 with scl high
  always_comb begin
    scl_nx = (state == IDLE || state == DONE) ? 1'b1 :
             state == START ? q != 2'd3 :
             state == STOP  ? q != 2'd0 : hi;
    low_nx = (state == START || state == RESTART) ? q[1] :
             state == STOP    ? !q[1] :
             state == TX_BYTE ? !sh[7] : 1'b0;
  end
  always_ff @(posedge clk_i)
    if (rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      err <= 1'b0;
      scl <= 1'b1;
      sda_low <= 1'b0;
      sh <= '0;
      bit_cnt <= '0;
      ph <= '0;
      ack_n <= 1'b0;
      addr <= '0;
      regs <= '0;
      data <= '0;
    end else begin
      scl <= scl_nx;
      sda_low <= low_nx;
      case (state)
        IDLE: if (start_en) begin
          addr <= i2c_device_addr[7:1];
          regs <= register;
          data <= data_byte;
          err <= 1'b0;
          busy <= 1'b1;
          state <= START;
        end
        START: if (bit_end) begin
          sh <= {addr, WR};
          bit_cnt <= '0;
          ph <= '0;
          state <= TX_BYTE;
        end
        TX_BYTE: if (bit_end) begin
          sh <= sh << 1;
          bit_cnt <= bit_cnt + 1'b1;
          state <= &bit_cnt ? RX_ACK : TX_BYTE;
        end
        RX_ACK: begin
          if (mid) ack_n <= sda;
          if (bit_end) begin
            ph <= ph + 1'b1;
            err <= ack_n;
            sh <= ph == 2'd0 ? regs[15:8] : ph == 2'd1 ? regs[7:0] : data;
            state <= ack_n ? STOP :
                     ph == 2'd3 ? (rd ? RX_BYTE : STOP) :
                     (ph == 2'd2 && rd) ? RESTART : TX_BYTE;
          end
        end
`ifdef IIC_READ_EN
        RESTART: if (bit_end) begin
          sh <= {addr, RD};
          state <= TX_BYTE;
        end
        RX_BYTE: begin
          if (mid) sh <= {sh[6:0], sda};
          if (bit_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            state <= &bit_cnt ? TX_NACK : RX_BYTE;
          end
        end
        TX_NACK: if (bit_end) state <= STOP;
`endif
        STOP: if (bit_end) state <= DONE;
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef IIC_READ_EN
  always_ff @(posedge clk_i)
    if (rst_n) begin
      rd <= WR;
      rd_data <= 8'h00;
    end else begin
      if (state == IDLE && start_en) rd <= wr_rd_flag;
      if (state == DONE && rd && !err) rd_data <= sh;
    end
`else
  assign rd = WR;
  assign rd_data = 8'h00;
`endif
endmodule

// File: tb/tb_iic_drive.sv
// tb_iic_drive: scoreboard bench with a bus monitor and an I2C slave at 0x78 returning 0x56
module tb_iic_drive;
  logic clk_i = 1'b0, rst_n = 1'b1, wr_rd_flag = 1'b0, start_en = 1'b0;
  logic [7:0] i2c_device_addr = '0, data_byte = '0;
  logic [15:0] register = '0;
  logic scl, busy, err;
  logic [7:0] rd_data;
  wire sda;
  logic slv_low = 1'b0;
  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;
  int n_vec = 0, n_bad = 0;
  logic [9:0] sb[$];
  localparam logic [9:0] EV_START = 10'h200, EV_STOP = 10'h201;
`ifdef IIC_READ_EN
  localparam logic [7:0] RD_EXP = 8'h56;
`else
  localparam logic [7:0] RD_EXP = 8'h00;
`endif

  iic_drive #(.QTR_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .wr_rd_flag(wr_rd_flag), .start_en(start_en),
    .i2c_device_addr(i2c_device_addr), .register(register), .data_byte(data_byte),
    .scl(scl), .sda(sda), .busy(busy), .err(err), .rd_data(rd_data)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [9:0] got);
    if (sb.size() == 0) chk({tag, "_extra"}, {22'd0, got}, 32'hFFFF);
    else chk(tag, {22'd0, got}, {22'd0, sb.pop_front()});
  endtask

  task automatic exp_byte(input logic [7:0] v, input logic nack);
    sb.push_back({1'b0, v, nack});
  endtask

  task automatic exp_write(input logic [7:0] a, input logic [15:0] r, input logic [7:0] d);
    sb.push_back(EV_START);
    exp_byte({a[7:1], 1'b0}, 1'b0);
    exp_byte(r[15:8], 1'b0);
    exp_byte(r[7:0], 1'b0);
    exp_byte(d, 1'b0);
    sb.push_back(EV_STOP);
  endtask

  // monitor + slave, evaluated away from the active edge
  logic pscl = 1'b1, psda = 1'b1, mon_en = 1'b0;
  logic first = 1'b0, addressed = 1'b0, reading = 1'b0, tx_mode = 1'b0;
  int bitn = 0;
  logic [7:0] b = '0, rdat = 8'h56;
  always @(negedge clk_i) begin
    logic s, d;
    s = scl;
    d = sda;
    if (mon_en) begin
      if (s && pscl && psda && !d) begin
        sb_pop("start", EV_START);
        bitn = 0; first = 1'b1; addressed = 1'b0; reading = 1'b0; tx_mode = 1'b0; slv_low = 1'b0;
      end else if (s && pscl && !psda && d) begin
        sb_pop("stop", EV_STOP);
      end else if (s && !pscl) begin
        if (bitn < 8) begin
          b = {b[6:0], d};
          bitn++;
          if (bitn == 8 && first) begin
            addressed = b[7:1] == 7'h3C;
            reading = addressed && b[0];
          end
        end else begin
          sb_pop("byte", {1'b0, b, d});
          bitn = 0;
          if (tx_mode && d) tx_mode = 1'b0;
          if (first) begin
            first = 1'b0;
            tx_mode = reading;
          end
        end
      end else if (!s && pscl) begin
        slv_low = bitn == 8 ? (!tx_mode && addressed) : (tx_mode && !rdat[7 - bitn]);
      end
    end
    pscl = s;
    psda = d;
  end

  task automatic txn(input logic [7:0] a, input logic [15:0] r, input logic [7:0] dv, input logic rd);
    @(negedge clk_i);
    i2c_device_addr = a; register = r; data_byte = dv; wr_rd_flag = rd; start_en = 1'b1;
    @(negedge clk_i);
    start_en = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_scl", {31'd0, scl}, 32'd1);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_i);
    mon_en = 1'b1;

    exp_write(8'h78, 16'h3008, 8'h82);
    txn(8'h78, 16'h3008, 8'h82, 1'b0);
    wait_idle("wr_done");
    chk("wr_err", {31'd0, err}, 32'd0);

`ifdef IIC_READ_EN
    sb.push_back(EV_START);
    exp_byte(8'h78, 1'b0);
    exp_byte(8'h30, 1'b0);
    exp_byte(8'h0A, 1'b0);
    sb.push_back(EV_START);
    exp_byte(8'h79, 1'b0);
    exp_byte(8'h56, 1'b1);
    sb.push_back(EV_STOP);
`else
    exp_write(8'h78, 16'h300A, 8'h5A);
`endif
    txn(8'h78, 16'h300A, 8'h5A, 1'b1);
    wait_idle("rd_done");
    chk("rd_err", {31'd0, err}, 32'd0);
    chk("rd_data", {24'd0, rd_data}, {24'd0, RD_EXP});

    sb.push_back(EV_START);
    exp_byte(8'h42, 1'b1);
    sb.push_back(EV_STOP);
    txn(8'h42, 16'h1111, 8'h33, 1'b0);
    wait_idle("nack_done");
    chk("nack_err", {31'd0, err}, 32'd1);
    chk("nack_rd_data", {24'd0, rd_data}, {24'd0, RD_EXP});

    exp_write(8'h78, 16'h1234, 8'hA5);
    txn(8'h78, 16'h1234, 8'hA5, 1'b0);
    chk("err_clear", {31'd0, err}, 32'd0);
    repeat (60) @(negedge clk_i);
    i2c_device_addr = 8'h42; register = 16'hFFFF; data_byte = 8'h00; wr_rd_flag = 1'b1;
    start_en = 1'b1;
    @(negedge clk_i);
    start_en = 1'b0;
    wait_idle("busy_start_done");
    repeat (100) @(negedge clk_i);
    chk("no_second_busy", {31'd0, busy}, 32'd0);
    chk("no_second_sb", sb.size(), 32'd0);
    chk("busy_start_err", {31'd0, err}, 32'd0);

    mon_en = 1'b0;
    txn(8'h78, 16'h3008, 8'h82, 1'b0);
    repeat (100) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("abort_scl", {31'd0, scl}, 32'd1);
    chk("abort_sda", {31'd0, sda}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    chk("abort_rd_data", {24'd0, rd_data}, 32'd0);
    rst_n = 1'b0;
    slv_low = 1'b0;
    repeat (4) @(negedge clk_i);
    bitn = 0; first = 1'b0; tx_mode = 1'b0; addressed = 1'b0;
    mon_en = 1'b1;

    exp_write(8'h78, 16'hABCD, 8'hEF);
    txn(8'h78, 16'hABCD, 8'hEF, 1'b0);
    wait_idle("recover_done");
    repeat (20) @(negedge clk_i);
    chk("sb_drain", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
